// File: rtl/axi_cmd_queue.sv
// axi_cmd_queue: command FIFO and single-outstanding sequencer for the AXI master.
// Buffers write/read requests, pops them in order, presents each on the aw*/w* or ar*
// group with a one-cycle start pulse and holds it until the master reports completion.
// Commands with the reserved burst code are dropped and flagged with cmd_err.
// Optional build macro CMD_QUEUE_STATS_EN adds wr_count, rd_count and err_count outputs.
module axi_cmd_queue #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [WIDTH-1:0]         cmd_addr,
    input  logic [WIDTH/8-1:0]       cmd_len,
    input  logic [SIZE-1:0]          cmd_size,
    input  logic [SIZE-2:0]          cmd_burst,
    input  logic [WIDTH/8-1:0]       cmd_id,
    input  logic [WIDTH-1:0]         cmd_wdata,
    input  logic [WIDTH/8-1:0]       cmd_wstrb,
    output logic [WIDTH-1:0]         awaddr,
    output logic [WIDTH/8-1:0]       awlen,
    output logic [SIZE-1:0]          awsize,
    output logic [SIZE-2:0]          awburst,
    output logic [WIDTH/8-1:0]       awid,
    output logic [WIDTH-1:0]         wdata,
    output logic [WIDTH/8-1:0]       wstrb,
    output logic [WIDTH-1:0]         araddr,
    output logic [WIDTH/8-1:0]       arlen,
    output logic [SIZE-1:0]          arsize,
    output logic [SIZE-2:0]          arburst,
    output logic [WIDTH/8-1:0]       arid,
    output logic                     start_wr,
    output logic                     start_rd,
    input  logic                     m_done,
    output logic                     busy,
    output logic                     cmd_err,
    output logic [$clog2(DEPTH):0]   level
`ifdef CMD_QUEUE_STATS_EN
    ,
    output logic [31:0]              wr_count,
    output logic [31:0]              rd_count,
    output logic [15:0]              err_count
`endif
);

    localparam int LW = WIDTH / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 1 + 2 * WIDTH + 3 * LW + SIZE + (SIZE - 1);
    localparam logic [PW:0]     FULL_LVL  = (PW + 1)'(DEPTH);
    localparam logic [PW:0]     LVL_ONE   = (PW + 1)'(1);
    localparam logic [SIZE-2:0] BURST_RSV = (SIZE - 1)'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PW:0]      r_level;
    logic             w_full, w_push, w_pop, w_load, w_bad;

    logic             w_h_write;
    logic [WIDTH-1:0] w_h_addr, w_h_wdata;
    logic [LW-1:0]    w_h_len, w_h_id, w_h_wstrb;
    logic [SIZE-1:0]  w_h_size;
    logic [SIZE-2:0]  w_h_burst;

    logic             r_is_write, r_cmd_err;
    logic [WIDTH-1:0] r_awaddr, r_wdata, r_araddr;
    logic [LW-1:0]    r_awlen, r_awid, r_wstrb, r_arlen, r_arid;
    logic [SIZE-1:0]  r_awsize, r_arsize;
    logic [SIZE-2:0]  r_awburst, r_arburst;

    assign w_full    = (r_level == FULL_LVL);
    assign cmd_ready = ~w_full & ~reset;
    assign w_push    = cmd_valid & cmd_ready;
    assign level     = r_level;

    assign {w_h_write, w_h_addr, w_h_len, w_h_size, w_h_burst, w_h_id, w_h_wdata, w_h_wstrb} =
        r_mem[r_rd_ptr];
    assign w_bad = (w_h_burst == BURST_RSV);

    // FIFO storage: write the incoming command at the tail (no reset needed on data)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_len, cmd_size, cmd_burst,
                                cmd_id, cmd_wdata, cmd_wstrb};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Sequencer next state, pop decision and start/busy outputs
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        start_wr    = 1'b0;
        start_rd    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop = 1'b1;
                    if (!w_bad) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                busy        = 1'b1;
                start_wr    = r_is_write;
                start_rd    = ~r_is_write;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (m_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command output registers: only the group matching the popped direction is reloaded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_write <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_awsize   <= '0;
            r_awburst  <= '0;
            r_awid     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_arburst  <= '0;
            r_arid     <= '0;
        end else begin
            r_cmd_err <= w_pop & w_bad;
            if (w_load) begin
                r_is_write <= w_h_write;
                if (w_h_write) begin
                    r_awaddr  <= w_h_addr;
                    r_awlen   <= w_h_len;
                    r_awsize  <= w_h_size;
                    r_awburst <= w_h_burst;
                    r_awid    <= w_h_id;
                    r_wdata   <= w_h_wdata;
                    r_wstrb   <= w_h_wstrb;
                end else begin
                    r_araddr  <= w_h_addr;
                    r_arlen   <= w_h_len;
                    r_arsize  <= w_h_size;
                    r_arburst <= w_h_burst;
                    r_arid    <= w_h_id;
                end
            end
        end
    end

    assign awaddr  = r_awaddr;
    assign awlen   = r_awlen;
    assign awsize  = r_awsize;
    assign awburst = r_awburst;
    assign awid    = r_awid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = r_arsize;
    assign arburst = r_arburst;
    assign arid    = r_arid;
    assign cmd_err = r_cmd_err;

`ifdef CMD_QUEUE_STATS_EN
    logic [31:0] r_wr_count, r_rd_count;
    logic [15:0] r_err_count;

    // Transfer statistics: issue counters wrap, error counter saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_count  <= '0;
            r_rd_count  <= '0;
            r_err_count <= '0;
        end else begin
            if (start_wr) r_wr_count <= r_wr_count + 32'd1;
            if (start_rd) r_rd_count <= r_rd_count + 32'd1;
            if (r_cmd_err && (r_err_count != '1)) r_err_count <= r_err_count + 16'd1;
        end
    end

    assign wr_count  = r_wr_count;
    assign rd_count  = r_rd_count;
    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_axi_cmd_queue.sv
// Scoreboard bench for axi_cmd_queue: stimulus pushes expected issue/error events,
// a forked monitor pops and compares them whenever a start or error pulse appears.
module tb_axi_cmd_queue;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic [3:0]  cmd_id = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  awlen, awid, wstrb, arlen, arid;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        start_wr, start_rd, busy, cmd_err;
    logic        m_done = 1'b0;
    logic [2:0]  level;
`ifdef CMD_QUEUE_STATS_EN
    logic [31:0] wr_count, rd_count;
    logic [15:0] err_count;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    cmd_t exp_q[$];
    cmd_t last_wr = '0;
    cmd_t last_rd = '0;

    axi_cmd_queue #(.WIDTH(32), .SIZE(3), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_burst(cmd_burst), .cmd_id(cmd_id), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .wdata(wdata), .wstrb(wstrb), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid), .start_wr(start_wr), .start_rd(start_rd),
        .m_done(m_done), .busy(busy), .cmd_err(cmd_err), .level(level)
`ifdef CMD_QUEUE_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic cmd_t mk(input logic wr, input logic [31:0] a, input logic [3:0] ln,
                                input logic [2:0] sz, input logic [1:0] b, input logic [3:0] id,
                                input logic [31:0] wd, input logic [3:0] ws);
        cmd_t c;
        c.wr = wr; c.addr = a; c.len = ln; c.size = sz; c.burst = b;
        c.id = id; c.wdata = wd; c.wstrb = ws;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input cmd_t c);
        cmd_write = c.wr; cmd_addr = c.addr; cmd_len = c.len; cmd_size = c.size;
        cmd_burst = c.burst; cmd_id = c.id; cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
        cmd_valid = 1'b1;
    endtask

    // Present one command for a single accepting edge; expectation queued on acceptance
    task automatic push(input cmd_t c);
        int waitc = 0;
        @(negedge clk);
        drive(c);
        #1;
        while (!cmd_ready && waitc < 50) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        chk("push_ready", cmd_ready, 1);
        if (cmd_ready) exp_q.push_back(c);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Completion pulse timed so the sequencer has reached WAIT
    task automatic done();
        repeat (3) @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
    endtask

    task automatic monitor();
        cmd_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && (start_wr || start_rd || cmd_err)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pulse", {start_wr, start_rd, cmd_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.burst == 2'd3) begin
                        chk("err_pulse", {start_wr, start_rd, cmd_err}, 3'b001);
                        chk("err_ar_held", araddr, last_rd.addr);
                        chk("err_aw_held", awaddr, last_wr.addr);
                    end else if (e.wr) begin
                        chk("wr_pulse", {start_wr, start_rd, cmd_err}, 3'b100);
                        chk("awaddr", awaddr, e.addr);
                        chk("aw_fields", {awlen, awsize, awburst, awid},
                            {e.len, e.size, e.burst, e.id});
                        chk("wdata", wdata, e.wdata);
                        chk("wstrb", wstrb, e.wstrb);
                        chk("ar_held", araddr, last_rd.addr);
                        last_wr = e;
                    end else begin
                        chk("rd_pulse", {start_wr, start_rd, cmd_err}, 3'b010);
                        chk("araddr", araddr, e.addr);
                        chk("ar_fields", {arlen, arsize, arburst, arid},
                            {e.len, e.size, e.burst, e.id});
                        chk("aw_held", awaddr, last_wr.addr);
                        last_rd = e;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        last_wr = '0;
        last_rd = '0;
        #1;
        chk("rst_pulses", {start_wr, start_rd, cmd_err, busy}, 0);
        chk("rst_cmd_out", {awaddr, araddr, wdata}, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", cmd_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        do_reset();

        // Single write: start pulse two cycles after the push edge
        push(mk(1'b1, 32'h100, 4'd3, 3'd2, 2'd1, 4'd5, 32'hDEADBEEF, 4'hF));
        @(negedge clk); #1;
        chk("t1_no_start_n1", start_wr, 0);
        chk("t1_level_n1", level, 1);
        @(negedge clk); #1;
        chk("t1_start_n2", start_wr, 1);
        chk("t1_awaddr", awaddr, 32'h100);
        chk("t1_awid", awid, 5);
        chk("t1_busy", busy, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("t1_busy_wait", busy, 1);
        done();
        #1;
        chk("t1_busy_after_done", busy, 0);

        // m_done in IDLE and ISSUE has no effect
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk); #1;
        chk("idle_done_ignored", busy, 0);
        push(mk(1'b0, 32'h200, 4'd1, 3'd2, 2'd2, 4'd7, 32'h0, 4'h0));
        repeat (3) @(negedge clk);
        m_done = 1'b0;
        #1;
        chk("issue_done_ignored", busy, 1);
        done();

        // Fill the queue behind an outstanding write
        push(mk(1'b1, 32'h1000, 4'd0, 3'd2, 2'd1, 4'd1, 32'h11111111, 4'h1));
        push(mk(1'b0, 32'h2000, 4'd1, 3'd1, 2'd0, 4'd2, 32'h0, 4'h0));
        push(mk(1'b1, 32'h3000, 4'd2, 3'd2, 2'd1, 4'd3, 32'h33333333, 4'h3));
        push(mk(1'b0, 32'h4000, 4'd3, 3'd0, 2'd2, 4'd4, 32'h0, 4'h0));
        chk("t2_level3", level, 3);
        push(mk(1'b1, 32'h5000, 4'd4, 3'd2, 2'd1, 4'd6, 32'h55555555, 4'h5));
        chk("t2_level4", level, 4);
        chk("t2_ready_full", cmd_ready, 0);

        // Full while a pop happens: the held command is not taken that cycle
        @(negedge clk);
        drive(mk(1'b0, 32'h6000, 4'd5, 3'd2, 2'd1, 4'd8, 32'h0, 4'h0));
        done();
        #1;
        chk("t4_ready_pop_cycle", cmd_ready, 0);
        chk("t4_level_pop_cycle", level, 4);
        @(negedge clk); #1;
        chk("t4_level_after_pop", level, 3);
        chk("t4_ready_after_pop", cmd_ready, 1);
        exp_q.push_back(mk(1'b0, 32'h6000, 4'd5, 3'd2, 2'd1, 4'd8, 32'h0, 4'h0));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("t4_level_refill", level, 4);
        repeat (5) done();

        // Reserved burst is dropped, following read issues normally
        push(mk(1'b0, 32'hBAD0, 4'd9, 3'd3, 2'd3, 4'd9, 32'h0, 4'h0));
        push(mk(1'b0, 32'h40, 4'd2, 3'd2, 2'd1, 4'd10, 32'h0, 4'h0));
        done();
        #1;
        chk("t3_araddr_final", araddr, 32'h40);

        // Reset while waiting with two commands queued
        push(mk(1'b1, 32'h7000, 4'd1, 3'd2, 2'd1, 4'd11, 32'h77777777, 4'h7));
        push(mk(1'b0, 32'h8000, 4'd1, 3'd2, 2'd1, 4'd12, 32'h0, 4'h0));
        push(mk(1'b1, 32'h9000, 4'd1, 3'd2, 2'd1, 4'd13, 32'h99999999, 4'h9));
        chk("t5_level2", level, 2);
        repeat (2) @(negedge clk);
        #1;
        chk("t5_busy_before_rst", busy, 1);
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        chk("t5_level_idle", level, 0);
        chk("t5_busy_idle", busy, 0);
        push(mk(1'b0, 32'hA000, 4'd0, 3'd2, 2'd0, 4'd14, 32'h0, 4'h0));
        done();

        // Statistics workload: 3 writes, 2 reads, 1 reserved burst
        do_reset();
        push(mk(1'b1, 32'hB000, 4'd0, 3'd2, 2'd1, 4'd1, 32'hB0B0B0B0, 4'hF));
        push(mk(1'b0, 32'hC000, 4'd0, 3'd2, 2'd1, 4'd2, 32'h0, 4'h0));
        push(mk(1'b1, 32'hD000, 4'd0, 3'd2, 2'd1, 4'd3, 32'hD0D0D0D0, 4'hF));
        push(mk(1'b1, 32'hE000, 4'd0, 3'd2, 2'd3, 4'd4, 32'hE0E0E0E0, 4'hF));
        done();
        done();
        done();
        push(mk(1'b1, 32'hF000, 4'd0, 3'd2, 2'd1, 4'd5, 32'hF0F0F0F0, 4'hF));
        push(mk(1'b0, 32'hF100, 4'd0, 3'd2, 2'd1, 4'd6, 32'h0, 4'h0));
        done();
        done();
        repeat (3) @(negedge clk);
        #1;
`ifdef CMD_QUEUE_STATS_EN
        chk("t6_wr_count", wr_count, 3);
        chk("t6_rd_count", rd_count, 2);
        chk("t6_err_count", err_count, 1);
`endif
        chk("end_busy", busy, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
